// File: rtl/matrix_loader_if.sv
// Element stream into matrix_loader: one matrix element per valid/ready handshake.
interface matrix_loader_if #(
  parameter int WIDTH = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;

  modport master (
    output in_valid,
    output in_data,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_data,
    output in_ready
  );
endinterface

// File: rtl/matrix_loader.sv
// Assembles a SIZE x SIZE matrix from a row-major element stream and drives one skew pass per matrix.
// Optional ping/pong buffering when MATRIX_LOADER_DOUBLE_BUFFER_EN is defined.
//
// state  | meaning
// FILL   | accepting elements into the buffer, ena/ena_cells low
// STREAM | matrix held stable, ena/ena_cells high for 2*SIZE-1 cycles
// GAP    | one cycle of ena without ena_cells so the downstream skew counter returns to 0
module matrix_loader #(
  parameter int WIDTH = 4,
  parameter int SIZE  = 3
) (
  input  logic             clock,
  input  logic             reset,
  matrix_loader_if.slave   stream,
  input  logic             abort,
  output logic [WIDTH-1:0] matrix_out [SIZE-1:0][SIZE-1:0],
  output logic             ena,
  output logic             ena_cells,
  output logic             busy,
  output logic             pass_done
);

  localparam int NELEM     = SIZE * SIZE;
  localparam int CW        = $clog2(NELEM + 1);
  localparam int RW        = $clog2(SIZE);
  localparam int PASS_LAST = 2 * SIZE - 2;
  localparam int PW        = $clog2(PASS_LAST + 1);

  typedef enum logic [1:0] {FILL, STREAM, GAP} state_t;

  state_t        state;
  logic [CW-1:0] elem_cnt;
  logic [RW-1:0] row_idx;
  logic [RW-1:0] col_idx;
  logic [PW-1:0] pass_cnt;
  logic          ready_q;
  logic          accept;
  logic          last_elem;

  // abort gates the handshake directly so an element offered in the abort cycle is never consumed
  assign stream.in_ready = ready_q & ~abort;
  assign accept          = stream.in_valid & stream.in_ready;
  assign last_elem       = (elem_cnt == CW'(NELEM - 1));

`ifdef MATRIX_LOADER_DOUBLE_BUFFER_EN
  logic             rd_bank;
  logic             wr_bank;
  logic             wr_full;
  logic [WIDTH-1:0] mem [1:0][SIZE-1:0][SIZE-1:0];

  assign wr_bank = ~rd_bank;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int b = 0; b < 2; b++)
        for (int r = 0; r < SIZE; r++)
          for (int c = 0; c < SIZE; c++)
            mem[b][r][c] <= '0;
    end else if (accept) begin
      mem[wr_bank][row_idx][col_idx] <= stream.in_data;
    end
  end

  always_comb begin
    for (int r = 0; r < SIZE; r++)
      for (int c = 0; c < SIZE; c++)
        matrix_out[r][c] = mem[rd_bank][r][c];
  end
`else
  logic [WIDTH-1:0] mem [SIZE-1:0][SIZE-1:0];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int r = 0; r < SIZE; r++)
        for (int c = 0; c < SIZE; c++)
          mem[r][c] <= '0;
    end else if (accept) begin
      mem[row_idx][col_idx] <= stream.in_data;
    end
  end

  always_comb begin
    for (int r = 0; r < SIZE; r++)
      for (int c = 0; c < SIZE; c++)
        matrix_out[r][c] = mem[r][c];
  end
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= FILL;
      elem_cnt  <= '0;
      row_idx   <= '0;
      col_idx   <= '0;
      pass_cnt  <= '0;
      ready_q   <= 1'b1;
      ena       <= 1'b0;
      ena_cells <= 1'b0;
      busy      <= 1'b0;
      pass_done <= 1'b0;
`ifdef MATRIX_LOADER_DOUBLE_BUFFER_EN
      rd_bank   <= 1'b0;
      wr_full   <= 1'b0;
`endif
    end else if (abort) begin
      state     <= FILL;
      elem_cnt  <= '0;
      row_idx   <= '0;
      col_idx   <= '0;
      pass_cnt  <= '0;
      ready_q   <= 1'b1;
      ena       <= 1'b0;
      ena_cells <= 1'b0;
      busy      <= 1'b0;
      pass_done <= 1'b0;
`ifdef MATRIX_LOADER_DOUBLE_BUFFER_EN
      wr_full   <= 1'b0;
`endif
    end else begin
      if (accept) begin
        if (last_elem) begin
          elem_cnt <= '0;
          row_idx  <= '0;
          col_idx  <= '0;
        end else begin
          elem_cnt <= elem_cnt + CW'(1);
          if (col_idx == RW'(SIZE - 1)) begin
            col_idx <= '0;
            row_idx <= row_idx + RW'(1);
          end else begin
            col_idx <= col_idx + RW'(1);
          end
        end
      end

      case (state)
        FILL: begin
          if (accept && last_elem) begin
            state     <= STREAM;
            pass_cnt  <= '0;
            ena       <= 1'b1;
            ena_cells <= 1'b1;
            busy      <= 1'b1;
`ifdef MATRIX_LOADER_DOUBLE_BUFFER_EN
            rd_bank   <= ~rd_bank;
            ready_q   <= 1'b1;
`else
            ready_q   <= 1'b0;
`endif
          end
        end

        STREAM: begin
          if (pass_cnt == PW'(PASS_LAST)) begin
            state     <= GAP;
            pass_cnt  <= '0;
            ena_cells <= 1'b0;
            pass_done <= 1'b0;
          end else begin
            pass_cnt  <= pass_cnt + PW'(1);
            pass_done <= (pass_cnt == PW'(PASS_LAST - 1));
          end
`ifdef MATRIX_LOADER_DOUBLE_BUFFER_EN
          if (accept && last_elem) begin
            wr_full <= 1'b1;
            ready_q <= 1'b0;
          end
`endif
        end

        GAP: begin
`ifdef MATRIX_LOADER_DOUBLE_BUFFER_EN
          // a bank completed during this very cycle counts as full
          if (wr_full || (accept && last_elem)) begin
            state     <= STREAM;
            rd_bank   <= ~rd_bank;
            wr_full   <= 1'b0;
            ready_q   <= 1'b1;
            ena_cells <= 1'b1;
          end else begin
            state     <= FILL;
            ena       <= 1'b0;
            busy      <= 1'b0;
          end
`else
          state   <= FILL;
          ena     <= 1'b0;
          busy    <= 1'b0;
          ready_q <= 1'b1;
`endif
        end

        default: state <= FILL;
      endcase
    end
  end

endmodule
